// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and default widths for the sequential signed divider
package seq_div_pkg;
   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;
   localparam int CW_DEF = $clog2(DW_DEF);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step (pr_in/bit_in/dv in, pr_out/q_bit out)
module div_step #(
   parameter int VW = 4
) (
   input  logic [VW:0]   pr_in,
   input  logic          bit_in,
   input  logic [VW-1:0] dv,
   output logic [VW:0]   pr_out,
   output logic          q_bit
);
   logic [VW+1:0] trial, diff;
   always_comb begin
      trial  = {pr_in, bit_in};
      diff   = trial - {2'b00, dv};
      // no borrow out of the trial subtraction means the divisor fits
      q_bit  = ~diff[VW+1];
      pr_out = q_bit ? diff[VW:0] : trial[VW:0];
   end
endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle signed divider (start/dividend/divisor in; quotient/remainder/busy/done/div_by_zero/overflow out)
module seq_div
   import seq_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero,
   output logic          overflow
);
   localparam int CW = $clog2(DW);
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] a_q, a_d, quotient_q, quotient_d;
   logic [VW-1:0] b_q, b_d, remainder_q, remainder_d;
   logic [VW:0]   pr_q, pr_d, pr_nx;
   logic          sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d, ovf_q, ovf_d, q_bit;

   // a_q holds the raw dividend, then its magnitude, and shifts quotient bits in as dividend bits leave
   div_step #(.VW(VW)) u_step (
      .pr_in (pr_q),
      .bit_in(a_q[DW-1]),
      .dv    (b_q),
      .pr_out(pr_nx),
      .q_bit (q_bit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      pr_d        = pr_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = PREP;
            a_d     = dividend;
            b_d     = divisor;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
         end
         PREP: begin
            sa_d  = a_q[DW-1];
            sb_d  = b_q[VW-1];
            a_d   = a_q[DW-1] ? -a_q : a_q;
            b_d   = b_q[VW-1] ? -b_q : b_q;
            pr_d  = '0;
            cnt_d = '0;
            if (b_q == '0) begin
               state_d     = DONE;
               quotient_d  = '1;
               remainder_d = '0;
               dbz_d       = 1'b1;
            end else begin
               state_d = ITER;
            end
         end
         ITER: begin
            a_d     = {a_q[DW-2:0], q_bit};
            pr_d    = pr_nx;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(DW - 1)) ? FIX : ITER;
         end
         FIX: begin
            quotient_d  = (sa_q ^ sb_q) ? -a_q : a_q;
            remainder_d = sa_q ? -pr_q[VW-1:0] : pr_q[VW-1:0];
            // an unsigned magnitude with the top bit set only fits when the result is negative
            ovf_d       = ~(sa_q ^ sb_q) & a_q[DW-1];
            state_d     = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         pr_q        <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         pr_q        <= pr_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = state_q != IDLE;
   assign done        = state_q == DONE;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized self-checking bench for seq_div against an arithmetic reference model
module tb_seq_div;
   logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [7:0] dividend = '0, quotient;
   logic [3:0] divisor = '0, remainder;
   logic       busy, done, div_by_zero, overflow;
   int         n_chk = 0, n_fail = 0;

   seq_div dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference: Verilog-style truncating division with the two special cases
   task automatic model(input int a, input int b, output int q, output int r, output int dz, output int ov);
      dz = 0;
      ov = 0;
      if (b == 0) begin
         q = -1; r = 0; dz = 1;
      end else if (a == -128 && b == -1) begin
         q = -128; r = 0; ov = 1;
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   task automatic run_op(input int a, input int b, input bit noise, input string tag);
      int q, r, dz, ov, lat;
      bit seen;
      model(a, b, q, r, dz, ov);
      @(negedge clk);
      dividend = 8'(a);
      divisor  = 4'(b);
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 30) begin
         @(posedge clk);
         #1 lat++;
         if (lat == 1) check({tag, " busy"}, int'(busy), 1);
         if (done) seen = 1'b1;
         else if (noise) begin
            start    = (lat < 9);
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
      end
      start = 1'b0;
      check({tag, " done_seen"}, int'(seen), 1);
      if (!seen) return;
      check({tag, " latency"}, lat + 1, (b == 0) ? 2 : 11);
      check({tag, " quotient"}, int'($signed(quotient)), q);
      check({tag, " remainder"}, int'($signed(remainder)), r);
      check({tag, " div_by_zero"}, int'(div_by_zero), dz);
      check({tag, " overflow"}, int'(overflow), ov);
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, int'(done), 0);
      check({tag, " busy_after"}, int'(busy), 0);
      check({tag, " held"}, int'($signed(quotient)), q);
   endtask

   initial begin
      int fb, passes;
      #1 rst = 1'b1;
      #2;
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset flags", int'({div_by_zero, overflow}), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_op(100, 7, 1'b0, "100/7");
      run_op(-100, 7, 1'b0, "-100/7");
      run_op(100, -8, 1'b0, "100/-8");
      run_op(-128, -1, 1'b0, "-128/-1");
      run_op(6, 3, 1'b0, "6/3");
      run_op(45, 0, 1'b0, "45/0");
      @(negedge clk);
      dividend = 8'd77;
      divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst quotient", int'(quotient), 0);
      check("midrst remainder", int'(remainder), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst done", int'(done), 0);
      check("midrst flags", int'({div_by_zero, overflow}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      run_op(77, 5, 1'b0, "77/5");
      run_op(50, 3, 1'b1, "ignored_start");
      run_op(-128, 1, 1'b0, "-128/1");
      passes = 0;
      for (int i = 0; i < 200; i++) begin
         int a, b;
         a  = (i % 50 == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
         b  = int'($urandom_range(0, 15)) - 8;
         fb = n_fail;
         run_op(a, b, 1'b0, $sformatf("rand%0d %0d/%0d", i, a, b));
         if (n_fail == fb) passes++;
      end
      $display("random sweep passes=%0d of 200", passes);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
